// File: rtl/nanci_phase_ctrl.sv
// Global phase sequencer for the Nanci PE mesh: LOAD -> (SORT -> COMPUTE) x ITERATIONS -> DRAIN -> DONE.
// Optional build macro NANCI_PHASE_STALL_EN adds i_stall, which freezes the sequence while busy.
module nanci_phase_ctrl #(
  parameter int unsigned ADDR_WIDTH     = 3,
  parameter int unsigned SORT_PASSES    = 3,
  parameter int unsigned SORT_CYCLES    = 1,
  parameter int unsigned COMPUTE_CYCLES = 1,
  parameter int unsigned ITERATIONS     = 1,
  parameter int unsigned CNT_WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
`ifdef NANCI_PHASE_STALL_EN
  input  logic                  i_stall,
`endif
  output logic [2:0]            o_phase,
  output logic                  o_sort_col,
  output logic [7:0]            o_sort_pass,
  output logic [7:0]            o_iter,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_we,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int unsigned MEM_LEN = 1 << ADDR_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_SORT    = 3'd2,
    ST_COMPUTE = 3'd3,
    ST_DRAIN   = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [7:0]           pass_q, pass_d;
  logic [7:0]           iter_q, iter_d;
  logic                 busy_c;
  logic                 stall_c;

  assign busy_c = (state_q == ST_LOAD) || (state_q == ST_SORT) ||
                  (state_q == ST_COMPUTE) || (state_q == ST_DRAIN);

`ifdef NANCI_PHASE_STALL_EN
  assign stall_c = i_stall & busy_c;
`else
  assign stall_c = 1'b0;
`endif

  // Next-state: the counter restarts at 0 on every phase or pass change.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    iter_d  = iter_q;
    if (!stall_c) begin
      unique case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            state_d = ST_LOAD;
            cnt_d   = '0;
            pass_d  = '0;
            iter_d  = '0;
          end
        end
        ST_LOAD: begin
          if (cnt_q == CNT_WIDTH'(MEM_LEN - 1)) begin
            state_d = ST_SORT;
            cnt_d   = '0;
            pass_d  = '0;
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end
        ST_SORT: begin
          if (cnt_q == CNT_WIDTH'(SORT_CYCLES - 1)) begin
            cnt_d = '0;
            if (pass_q == 8'(SORT_PASSES - 1)) begin
              state_d = ST_COMPUTE;
              pass_d  = '0;
            end else begin
              pass_d = pass_q + 8'd1;
            end
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end
        ST_COMPUTE: begin
          if (cnt_q == CNT_WIDTH'(COMPUTE_CYCLES - 1)) begin
            cnt_d = '0;
            if (iter_q != 8'(ITERATIONS - 1)) begin
              state_d = ST_SORT;
              iter_d  = iter_q + 8'd1;
              pass_d  = '0;
            end else begin
              state_d = ST_DRAIN;
            end
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end
        ST_DRAIN: begin
          if (cnt_q == CNT_WIDTH'(MEM_LEN - 1)) begin
            state_d = ST_DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          pass_d  = '0;
          iter_d  = '0;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          pass_d  = '0;
          iter_d  = '0;
        end
      endcase
    end
  end

  // State and Moore outputs, all registered from the next-state values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      pass_q      <= '0;
      iter_q      <= '0;
      o_phase     <= '0;
      o_sort_col  <= 1'b0;
      o_sort_pass <= '0;
      o_iter      <= '0;
      o_mem_addr  <= '0;
      o_mem_we    <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pass_q      <= pass_d;
      iter_q      <= iter_d;
      o_phase     <= state_d;
      o_sort_col  <= pass_d[0];
      o_sort_pass <= pass_d;
      o_iter      <= iter_d;
      o_mem_addr  <= ((state_d == ST_LOAD) || (state_d == ST_DRAIN)) ?
                     cnt_d[ADDR_WIDTH-1:0] : '0;
      o_mem_we    <= (state_d == ST_LOAD) && !stall_c;
      o_busy      <= (state_d == ST_LOAD) || (state_d == ST_SORT) ||
                     (state_d == ST_COMPUTE) || (state_d == ST_DRAIN);
      o_done      <= (state_d == ST_DONE);
    end
  end

endmodule

// File: tb/tb_nanci_phase_ctrl.sv
// Bench for nanci_phase_ctrl: two instances (default and ITERATIONS=2/SORT_CYCLES=2) checked
// cycle by cycle against an arithmetic timeline model.
module tb_nanci_phase_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic start;
  bit   sel;
  logic start_a, start_b;
  int   total_cnt = 0;
  int   bad_cnt   = 0;

  always #5 clk = ~clk;

  assign start_a = start & ~sel;
  assign start_b = start & sel;

  logic [2:0] a_phase, b_phase;
  logic       a_col, b_col;
  logic [7:0] a_pass, b_pass, a_iter, b_iter;
  logic [2:0] a_addr, b_addr;
  logic       a_we, b_we, a_busy, b_busy, a_done, b_done;

  nanci_phase_ctrl u_dut_a (
    .clk(clk), .rst(rst), .i_start(start_a),
`ifdef NANCI_PHASE_STALL_EN
    .i_stall(1'b0),
`endif
    .o_phase(a_phase), .o_sort_col(a_col), .o_sort_pass(a_pass), .o_iter(a_iter),
    .o_mem_addr(a_addr), .o_mem_we(a_we), .o_busy(a_busy), .o_done(a_done)
  );

  nanci_phase_ctrl #(.SORT_CYCLES(2), .ITERATIONS(2)) u_dut_b (
    .clk(clk), .rst(rst), .i_start(start_b),
`ifdef NANCI_PHASE_STALL_EN
    .i_stall(1'b0),
`endif
    .o_phase(b_phase), .o_sort_col(b_col), .o_sort_pass(b_pass), .o_iter(b_iter),
    .o_mem_addr(b_addr), .o_mem_we(b_we), .o_busy(b_busy), .o_done(b_done)
  );

  function automatic int n_passes();  return 3;              endfunction
  function automatic int n_sortc();   return sel ? 2 : 1;    endfunction
  function automatic int n_comp();    return 1;              endfunction
  function automatic int n_iters();   return sel ? 2 : 1;    endfunction
  function automatic int run_len();
    return 16 + n_iters() * (n_passes() * n_sortc() + n_comp());
  endfunction

  // Expected outputs t cycles after the start edge (t<=0: idle).
  function automatic logic [25:0] model(input int t);
    int L, R, P, S, I, u, v, r;
    logic [2:0] ph;
    logic [7:0] pass, iter;
    logic [2:0] addr;
    logic col, we, busy, done;
    P = n_passes(); S = n_sortc(); I = n_iters();
    L = 8; R = P * S + n_comp();
    ph = 3'd0; pass = 8'd0; iter = 8'd0; addr = 3'd0;
    col = 1'b0; we = 1'b0; busy = 1'b0; done = 1'b0;
    if (t >= 1 && t <= L) begin
      ph = 3'd1; addr = 3'(t - 1); we = 1'b1; busy = 1'b1;
    end else if (t > L) begin
      u = t - L - 1;
      if (u < I * R) begin
        iter = 8'(u / R);
        r = u % R;
        busy = 1'b1;
        if (r < P * S) begin
          ph = 3'd2; pass = 8'(r / S); col = pass[0];
        end else begin
          ph = 3'd3;
        end
      end else begin
        v = u - I * R;
        if (v < L) begin
          ph = 3'd4; addr = 3'(v); busy = 1'b1; iter = 8'(I - 1);
        end else if (v == L) begin
          ph = 3'd5; done = 1'b1; iter = 8'(I - 1);
        end
      end
    end
    return {ph, col, pass, iter, addr, we, busy, done};
  endfunction

  function automatic logic [25:0] observed();
    if (sel) return {b_phase, b_col, b_pass, b_iter, b_addr, b_we, b_busy, b_done};
    return {a_phase, a_col, a_pass, a_iter, a_addr, a_we, a_busy, a_done};
  endfunction

  task automatic check(input string tag, input logic [25:0] exp);
    logic [25:0] obs;
    obs = observed();
    total_cnt++;
    assert (obs === exp) else begin
      bad_cnt++;
      $error("FAIL %s dut=%0d observed=%h expected=%h", tag, sel, obs, exp);
    end
  endtask

  task automatic do_abort();
    #1 rst = 1'b0;
    #1 check("abort_async", 26'd0);
    start = 1'b0;
    @(negedge clk);
    check("abort_hold", 26'd0);
    rst = 1'b1;
    @(negedge clk);
    check("abort_idle", 26'd0);
  endtask

  // Entry: at a negedge, DUT idle, start already 1.
  task automatic run_one(input int abort_t, input bit chain);
    int total;
    total = run_len();
    for (int t = 1; t <= total + 2; t++) begin
      @(negedge clk);
      check($sformatf("run_t%0d", t), model(t));
      if (t == abort_t) begin
        do_abort();
        return;
      end
      start = (t <= total + 1) ? 1'($urandom_range(0, 1)) : chain;
    end
  endtask

  task automatic idle_cycles(input int n);
    start = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check("idle", 26'd0);
    end
  endtask

  initial begin
    int gap, ab;
    sel = 1'b0;
    rst = 1'b0;
    start = 1'b1;
    #12;
    check("reset_a", 26'd0);
    sel = 1'b1;
    check("reset_b", 26'd0);
    sel = 1'b0;
    @(negedge clk);
    start = 1'b0;
    rst = 1'b1;
    idle_cycles(10);

    start = 1'b1; run_one(0, 1'b0);
    idle_cycles(2);
    sel = 1'b1;
    start = 1'b1; run_one(0, 1'b0);
    idle_cycles(1);
    sel = 1'b0;
    start = 1'b1; run_one(10, 1'b0);
    idle_cycles(1);
    start = 1'b1; run_one(0, 1'b1);
    run_one(0, 1'b1);
    run_one(0, 1'b0);
    sel = 1'b1;
    start = 1'b1; run_one(0, 1'b1);
    run_one(0, 1'b0);

    for (int n = 0; n < 12; n++) begin
      gap = $urandom_range(0, 3);
      idle_cycles(gap);
      sel = 1'($urandom_range(0, 1));
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, run_len() + 1) : 0;
      start = 1'b1;
      run_one(ab, 1'b0);
    end
    idle_cycles(2);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
